// File: rtl/rate_pulse_gen.sv
// rate_pulse_gen: rate divider producing a single-cycle enable pulse for the
// downstream display counter at a switch-selectable rate.
//
// Ports:
//   clock     - system clock; all state updates on its rising edge
//   Clear     - synchronous, active-high reset
//   Enable    - run control; low holds the count and suppresses pulses
//   Speed     - rate select: 00 every cycle, 01 CLK_HZ, 10 2*CLK_HZ, 11 4*CLK_HZ
//   Pulse     - registered one-cycle enable pulse
//   Remaining - current down-counter value (cycles left until next pulse)
module rate_pulse_gen #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned WIDTH  = 28
) (
   input  logic             clock,
   input  logic             Clear,
   input  logic             Enable,
   input  logic [1:0]       Speed,
   output logic             Pulse,
   output logic [WIDTH-1:0] Remaining
);

   // Reload values (period minus one) for each rate, held at full counter width.
   localparam logic [WIDTH-1:0] RELOAD_00 = '0;
   localparam logic [WIDTH-1:0] RELOAD_01 = WIDTH'(CLK_HZ - 1);
   localparam logic [WIDTH-1:0] RELOAD_10 = WIDTH'((2 * CLK_HZ) - 1);
   localparam logic [WIDTH-1:0] RELOAD_11 = WIDTH'((4 * CLK_HZ) - 1);

   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic             pulse_q, pulse_d;
   logic [1:0]       speed_q, speed_d;
   logic [WIDTH-1:0] reload_new_c;
   logic [WIDTH-1:0] reload_cur_c;

   // Map a rate select code to its reload value.
   function automatic logic [WIDTH-1:0] reload_f(input logic [1:0] sel);
      logic [WIDTH-1:0] val;
      case (sel)
         2'b00:   val = RELOAD_00;
         2'b01:   val = RELOAD_01;
         2'b10:   val = RELOAD_10;
         default: val = RELOAD_11;
      endcase
      return val;
   endfunction

   assign reload_new_c = reload_f(Speed);
   assign reload_cur_c = reload_f(speed_q);

   // Next-state: a speed change restarts the period and never pulses,
   // regardless of Enable; otherwise count down while enabled.
   always_comb begin
      remaining_d = remaining_q;
      pulse_d     = 1'b0;
      speed_d     = speed_q;
      if (Speed != speed_q) begin
         remaining_d = reload_new_c;
         speed_d     = Speed;
      end else if (Enable) begin
         if (remaining_q == '0) begin
            pulse_d     = 1'b1;
            remaining_d = reload_cur_c;
         end else begin
            remaining_d = remaining_q - WIDTH'(1);
         end
      end
   end

   // State registers; Clear overrides everything including a due pulse.
   always_ff @(posedge clock) begin
      if (Clear) begin
         remaining_q <= reload_new_c;
         speed_q     <= Speed;
         pulse_q     <= 1'b0;
      end else begin
         remaining_q <= remaining_d;
         speed_q     <= speed_d;
         pulse_q     <= pulse_d;
      end
   end

   assign Pulse     = pulse_q;
   assign Remaining = remaining_q;

endmodule
